// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// branch_resolve_ctrl: resolves EX branches, flushes wrong path, redirects
// fetch and trains the branch predictor.  Revision: 1.0
// ============================================================================
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ex_valid,
  input  logic             ex_br,
  input  logic             ex_hold,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred,
  input  logic [31:0]      ex_pred_target,
  input  logic             ihit,
  input  logic             clr_stats,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             bp_br,
  output logic             bp_br_result,
  output logic [31:0]      bp_brPC,
  output logic [31:0]      bp_braddr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        res;
  logic        miss;
  logic [31:0] correct_pc;

  // Branches seen while a redirect is pending are wrong-path and never resolve.
  assign res  = ex_valid & ex_br & ~ex_hold & (state == IDLE);
  assign miss = res & ((ex_pred != ex_taken) |
                       (ex_pred & ex_taken & (ex_pred_target != ex_target)));

  assign correct_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

  assign redirect   = (state == REDIRECT);
  assign flush_ifid = miss | (state == REDIRECT);
  assign flush_idex = miss;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (miss) state_nxt = REDIRECT;
      REDIRECT: if (ihit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      redirect_pc  <= 32'd0;
      bp_br        <= 1'b0;
      bp_br_result <= 1'b0;
      bp_brPC      <= 32'd0;
      bp_braddr    <= 32'd0;
      br_count     <= '0;
      miss_count   <= '0;
    end else begin
      state <= state_nxt;
      bp_br <= res;
      if (miss) redirect_pc <= correct_pc;
      if (res) begin
        bp_br_result <= ex_taken;
        bp_brPC      <= ex_pc;
        bp_braddr    <= ex_target;
      end
      if (clr_stats) begin
        br_count   <= '0;
        miss_count <= '0;
      end else begin
        if (res)  br_count   <= br_count + CNT_W'(1);
        if (miss) miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_ctrl: scoreboard bench with a behavioural model of
// branch_resolve_ctrl driven by directed and random stimulus.  Revision: 1.0
// ============================================================================
module tb_branch_resolve_ctrl;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             ex_valid = 1'b0, ex_br = 1'b0, ex_hold = 1'b0, ex_taken = 1'b0;
  logic [31:0]      ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic             ex_pred = 1'b0, ihit = 1'b0, clr_stats = 1'b0;
  logic             flush_ifid, flush_idex, redirect, bp_br, bp_br_result;
  logic [31:0]      redirect_pc, bp_brPC, bp_braddr;
  logic [CNT_W-1:0] br_count, miss_count;

  branch_resolve_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_br(ex_br), .ex_hold(ex_hold), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred(ex_pred),
    .ex_pred_target(ex_pred_target), .ihit(ihit), .clr_stats(clr_stats),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .bp_br(bp_br), .bp_br_result(bp_br_result), .bp_brPC(bp_brPC),
    .bp_braddr(bp_braddr), .br_count(br_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: a pending-redirect flag, expected counts and queues.
  int              n_cmp = 0;
  int              n_fail = 0;
  bit              pend = 1'b0;
  logic [31:0]     exp_rpc = '0;
  int unsigned     exp_br = 0, exp_miss = 0;
  logic [64:0]     upd_q[$];
  logic [31:0]     rd_q[$];
  logic            rd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend = 1'b0; exp_rpc = '0; exp_br = 0; exp_miss = 0;
    upd_q.delete(); rd_q.delete();
  endtask

  task automatic drive(input bit v, input bit b, input bit h, input bit tk,
                       input logic [31:0] pc, input logic [31:0] tg,
                       input bit pd, input logic [31:0] pt, input bit ih, input bit clr);
    bit r, m;
    @(negedge CLK);
    ex_valid = v; ex_br = b; ex_hold = h; ex_taken = tk; ex_pc = pc;
    ex_target = tg; ex_pred = pd; ex_pred_target = pt; ihit = ih; clr_stats = clr;
    #1;
    r = v && b && !h && !pend;
    m = r && ((pd != tk) || (pd && pt != tg));
    chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, m || pend});
    chk("flush_idex", {31'd0, flush_idex}, {31'd0, m});
    if (r) upd_q.push_back({tk, pc, tg});
    if (clr) begin
      exp_br = 0; exp_miss = 0;
    end else begin
      exp_br   = (exp_br + (r ? 1 : 0)) % 65536;
      exp_miss = (exp_miss + (m ? 1 : 0)) % 65536;
    end
    if (pend) begin
      if (ih) pend = 1'b0;
    end else if (m) begin
      pend    = 1'b1;
      exp_rpc = tk ? tg : pc + 32'd4;
      rd_q.push_back(exp_rpc);
    end
  endtask

  task automatic idle(input bit ih);
    drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0, ih, 0);
  endtask

  // Monitor: compares registered outputs just after each rising edge.
  initial begin
    logic [64:0] u;
    forever begin
      @(posedge CLK);
      #1;
      if (!nRST) begin
        rd_prev = 1'b0;
      end else begin
        chk("redirect", {31'd0, redirect}, {31'd0, pend});
        chk("redirect_pc", redirect_pc, exp_rpc);
        chk("br_count", {16'd0, br_count}, exp_br);
        chk("miss_count", {16'd0, miss_count}, exp_miss);
        chk("bp_br", {31'd0, bp_br}, {31'd0, upd_q.size() != 0});
        if (upd_q.size() != 0) begin
          u = upd_q.pop_front();
          if (bp_br) begin
            chk("bp_br_result", {31'd0, bp_br_result}, {31'd0, u[64]});
            chk("bp_brPC", bp_brPC, u[63:32]);
            chk("bp_braddr", bp_braddr, u[31:0]);
          end
        end
        if (redirect && !rd_prev) begin
          if (rd_q.size() != 0) chk("redirect_pc_at_start", redirect_pc, rd_q.pop_front());
          else chk("redirect_unexpected", {31'd0, redirect}, 32'd0);
        end
        rd_prev = redirect;
      end
    end
  end

  initial begin
    logic [31:0] pcs[4];
    logic [31:0] pc, tg;
    bit          tk, pd;
    pcs[0] = 32'h0000_0100; pcs[1] = 32'hFFFF_FFFC; pcs[2] = 32'h0000_0080; pcs[3] = 32'h1234_5670;

    model_clear();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_bp_br", {31'd0, bp_br}, 32'd0);
    chk("rst_br_count", {16'd0, br_count}, 32'd0);
    chk("rst_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Correct not-taken
    drive(1, 1, 0, 0, 32'h100, 32'h180, 0, 32'h0, 0, 0);
    idle(0); idle(0);
    // Predicted not-taken, actually taken; ihit low three cycles
    drive(1, 1, 0, 1, 32'h40, 32'h200, 0, 32'h0, 0, 0);
    idle(0); idle(0); idle(0); idle(1); idle(0);
    // Predicted taken, not taken; ihit in t must not end the redirect
    drive(1, 1, 0, 0, 32'h80, 32'h500, 1, 32'h500, 1, 0);
    idle(1); idle(0);
    drive(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h500, 1, 32'h500, 0, 0);
    idle(0); idle(1); idle(0);
    // Wrong target
    drive(1, 1, 0, 1, 32'h10, 32'h400, 1, 32'h300, 0, 0);
    idle(1); idle(0);
    // Held branch, then a wrong-path branch during REDIRECT
    repeat (3) drive(1, 1, 1, 1, 32'h20, 32'h600, 1, 32'h600, 0, 0);
    drive(1, 1, 0, 1, 32'h20, 32'h600, 1, 32'h600, 0, 0);
    idle(0);
    drive(1, 1, 0, 1, 32'h30, 32'h700, 0, 32'h0, 0, 0);
    drive(1, 1, 0, 0, 32'h34, 32'h800, 1, 32'h800, 0, 0);
    idle(1); idle(0);
    // Reset during REDIRECT
    drive(1, 1, 0, 1, 32'h50, 32'h900, 0, 32'h0, 0, 0);
    idle(0);
    @(negedge CLK);
    ex_valid = 0; ex_br = 0; ihit = 0; clr_stats = 0;
    #2;
    nRST = 1'b0;
    model_clear();
    #1;
    chk("nrst_redirect", {31'd0, redirect}, 32'd0);
    chk("nrst_redirect_pc", redirect_pc, 32'd0);
    chk("nrst_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    chk("nrst_bp_br", {31'd0, bp_br}, 32'd0);
    chk("nrst_miss_count", {16'd0, miss_count}, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    idle(0); idle(1); idle(0);
    // clr_stats together with a resolution
    drive(1, 1, 0, 0, 32'h60, 32'h0, 0, 32'h0, 0, 0);
    drive(1, 1, 0, 1, 32'h64, 32'hA00, 0, 32'h0, 0, 1);
    idle(1); idle(0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? pcs[$urandom_range(0, 3)] : ($urandom & 32'hFFFF_FFFC);
      tg = $urandom & 32'hFFFF_FFFC;
      tk = $urandom_range(0, 1) == 1;
      pd = $urandom_range(0, 1) == 1;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            tk, pc, tg, pd, ($urandom_range(0, 3) != 0) ? tg : ($urandom & 32'hFFFF_FFFC),
            $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end
    idle(1); idle(0); idle(0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Branch resolution and misprediction recovery controller for the 5-stage pipeline. It sits between the EX stage and the fetch stage. It compares each resolved conditional branch against the prediction carried down from fetch, and flushes the wrong-path IF/ID and ID/EX contents. It sequences the PC redirect against instruction-memory handshakes, drives the 4-entry branch predictor's update port, and keeps branch and mispredict counters.

## Interface
- CNT_W, 16, width of the statistics counters
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX stage holds a valid instruction
- ex_br  in  1  EX instruction is a conditional branch
- ex_hold  in  1  EX/MEM latch not advancing this cycle (stall)
- ex_taken  in  1  actual branch outcome
- ex_pc  in  32  PC of the EX branch
- ex_target  in  32  computed branch target
- ex_pred  in  1  fetch predicted taken (predictor `taken` carried through the pipeline)
- ex_pred_target  in  32  target used by fetch when ex_pred=1
- ihit  in  1  instruction memory completed a fetch; PC register advances this cycle
- clr_stats  in  1  synchronous clear of both counters
- flush_ifid  out  1  kill IF/ID contents at the next edge
- flush_idex  out  1  kill ID/EX contents at the next edge
- redirect  out  1  fetch PC mux selects redirect_pc
- redirect_pc  out  32  corrected fetch address
- bp_br  out  1  predictor update strobe
- bp_br_result  out  1  outcome for the update
- bp_brPC  out  32  branch PC for the update
- bp_braddr  out  32  branch target for the update
- br_count  out  CNT_W  resolved branches
- miss_count  out  CNT_W  mispredicted branches

## Operation
- Resolution event (res) = ex_valid & ex_br & ~ex_hold & (state==IDLE).
  - Exactly one res occurs per branch, however long the hold lasts.
- Mispredict (miss) = res & one of:
  - ex_pred=0 and ex_taken=1
  - ex_pred=1 and ex_taken=0
  - ex_pred=1, ex_taken=1 and ex_pred_target != ex_target
- Correct PC:
  - ex_taken=1: ex_target.
  - ex_taken=0: ex_pc+4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- FSM states:
  - IDLE: on miss, latch redirect_pc and go to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: assert redirect and flush_ifid. Go to IDLE on the cycle ihit=1, which is the cycle the PC loads redirect_pc.
- Flushes:
  - flush_ifid = miss | (state==REDIRECT), combinational.
  - flush_idex = miss only.
  - Any instruction fetched from the wrong path while a redirect is pending never enters IF/ID.
- Branches in EX while in REDIRECT are wrong-path. They are ignored: no update, no count, no new miss.
- Predictor update: on every res, register {bp_br_result=ex_taken, bp_brPC=ex_pc, bp_braddr=ex_target}. Pulse bp_br for exactly one cycle.
  - The update is issued for both taken and not-taken outcomes, so the 2-bit counter trains in both directions.
- Counters:
  - br_count increments on res.
  - miss_count increments on miss.
  - Both wrap at 2^CNT_W.
  - clr_stats takes priority over an increment in the same cycle.

## Timing
- Reset values: state=IDLE; redirect=0, redirect_pc=0, bp_br=0, bp_br_result=0, bp_brPC=0, bp_braddr=0, br_count=0, miss_count=0.
  - flush_* follow their equations, so they are 0 while ex_valid=0.
- nRST mid-REDIRECT: everything returns to reset values immediately. No redirect is issued after release.
- Cycle t = cycle in which res/miss is true.
  - flush_ifid and flush_idex are high in t.
  - bp_br is high in t+1 only.
  - Counters show the new value in t+1.
  - redirect is high from t+1 through the first cycle with ihit=1, inclusive, and low the following cycle.
  - Minimum redirect length is 1 cycle, when ihit=1 in t+1.
- ihit in cycle t itself does not complete the redirect; the wrong-path fetch it completes is killed by flush_ifid.
- redirect_pc holds its value after leaving REDIRECT until the next miss.
- Simultaneous clr_stats and res: counters read 0 in t+1.

## Test plan
- Correct not-taken: ex_pc=0x100, ex_pred=0, ex_taken=0.
  - t: no flush.
  - t+1: bp_br=1, bp_br_result=0, bp_brPC=0x100; br_count=1, miss_count=0.
  - redirect never asserted.
- Predicted not-taken, actually taken: ex_pc=0x40, ex_target=0x200, ihit low for 3 cycles after t.
  - t: flush_ifid=flush_idex=1.
  - redirect=1 and redirect_pc=0x200 for t+1..t+4, ihit=1 in t+4, redirect=0 in t+5.
  - flush_ifid=1 throughout; miss_count=1.
- Predicted taken, not taken: ex_pc=0x80 gives redirect_pc=0x84. ex_pc=0xFFFFFFFC gives redirect_pc=0x00000000.
- Wrong target: ex_pred=1, ex_taken=1, ex_pred_target=0x300, ex_target=0x400.
  - miss; redirect_pc=0x400; bp_braddr=0x400.
- Held branch: ex_hold=1 for 3 cycles with the branch valid, then 0.
  - Exactly one bp_br pulse, in the cycle after hold drops; br_count +1.
  - A second branch presented during REDIRECT produces no update.
- nRST asserted during REDIRECT: all outputs 0 at once and counters 0. After release, redirect stays 0 until a new miss. clr_stats with res in the same cycle leaves counters at 0.
